pipeline_scoreboard: RTL and testbench

//  Parametrised hazard/forwarding controller for the ARM pipeline; successor to the fixed two-stage hazard check.

---
 rtl/pipeline_scoreboard.sv | 121 ++++++++++++
 tb/tb_pipeline_scoreboard.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_scoreboard.sv
// rtl/pipeline_scoreboard.sv - in-flight writer tracking with ID stall and operand forward selection
module pipeline_scoreboard #(
  parameter int REG_ADDR_W       = 4,
  parameter int DEPTH            = 3,
  parameter bit FWD_EN           = 1'b1,
  parameter bit RF_WRITE_THROUGH = 1'b1,
  parameter int SEL_W            = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_wb_en,
  input  logic                  id_is_load,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic                  src1_used,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  two_src,
  input  logic                  flush,
  output logic                  stall,
  output logic [SEL_W-1:0]      fwd_sel1,
  output logic [SEL_W-1:0]      fwd_sel2,
  output logic                  busy,
  output logic [31:0]           stall_cycles
);

  // The writeback slot is invisible to hazard checks when the regfile writes through.
  localparam int MATCH_DEPTH = RF_WRITE_THROUGH ? DEPTH - 1 : DEPTH;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      wb_en_q, wb_en_d;
  logic [DEPTH-1:0]      is_load_q, is_load_d;
  logic [REG_ADDR_W-1:0] dest_q [DEPTH];
  logic [REG_ADDR_W-1:0] dest_d [DEPTH];
  logic [31:0]           stall_cycles_q, stall_cycles_d;

  logic             hit1, hit2;
  logic             load1, load2;
  logic             hazard1, hazard2;
  logic [SEL_W-1:0] sel1, sel2;
  logic             load_slot0;

  // Scan oldest to youngest so the youngest matching writer overrides older ones.
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    load1 = 1'b0;
    load2 = 1'b0;
    sel1  = '0;
    sel2  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (k < MATCH_DEPTH && valid_q[k] && wb_en_q[k] && dest_q[k] == src1) begin
        hit1  = 1'b1;
        sel1  = SEL_W'(k + 1);
        load1 = is_load_q[k] && (k == 0);
      end
      if (k < MATCH_DEPTH && valid_q[k] && wb_en_q[k] && dest_q[k] == src2) begin
        hit2  = 1'b1;
        sel2  = SEL_W'(k + 1);
        load2 = is_load_q[k] && (k == 0);
      end
    end
  end

  always_comb begin
    hazard1  = 1'b0;
    hazard2  = 1'b0;
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    if (FWD_EN) begin
      hazard1 = src1_used && hit1 && load1;
      hazard2 = two_src && hit2 && load2;
      if (src1_used && hit1 && !hazard1) fwd_sel1 = sel1;
      if (two_src && hit2 && !hazard2) fwd_sel2 = sel2;
    end else begin
      hazard1 = src1_used && hit1;
      hazard2 = two_src && hit2;
    end
    stall = id_valid && !flush && (hazard1 || hazard2);
    busy  = |valid_q;
  end

  always_comb begin
    valid_d   = valid_q;
    wb_en_d   = wb_en_q;
    is_load_d = is_load_q;
    dest_d    = dest_q;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      valid_d[k]   = valid_q[k-1];
      wb_en_d[k]   = wb_en_q[k-1];
      is_load_d[k] = is_load_q[k-1];
      dest_d[k]    = dest_q[k-1];
    end
    load_slot0   = id_valid && !stall && !flush;
    valid_d[0]   = load_slot0;
    wb_en_d[0]   = load_slot0 && id_wb_en;
    is_load_d[0] = load_slot0 && id_is_load;
    dest_d[0]    = id_dest;
    stall_cycles_d = stall_cycles_q;
    if (stall && stall_cycles_q != 32'hFFFF_FFFF) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q        <= '0;
      wb_en_q        <= '0;
      is_load_q      <= '0;
      stall_cycles_q <= '0;
      for (int k = 0; k < DEPTH; k++) dest_q[k] <= '0;
    end else begin
      valid_q        <= valid_d;
      wb_en_q        <= wb_en_d;
      is_load_q      <= is_load_d;
      stall_cycles_q <= stall_cycles_d;
      for (int k = 0; k < DEPTH; k++) dest_q[k] <= dest_d[k];
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// tb/tb_pipeline_scoreboard.sv - randomized and directed checks of pipeline_scoreboard against a slot model
module tb_pipeline_scoreboard;
  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_wb_en, id_is_load, src1_used, two_src, flush;
  logic [3:0]  id_dest, src1, src2;
  logic        stall_f, busy_f, stall_n, busy_n;
  logic [1:0]  sel1_f, sel2_f, sel1_n, sel2_n;
  logic [31:0] cnt_f_o, cnt_n_o;

  typedef struct packed {
    logic       v;
    logic       wb;
    logic       ld;
    logic [3:0] d;
  } ent_t;

  ent_t [DEPTH-1:0] mf, mn;
  int unsigned mcnt_f, mcnt_n;
  int errors = 0;
  int checks = 0;
  logic        last_stall_f, last_stall_n;
  logic [1:0]  last_sel1_f, last_sel2_f;
  logic [31:0] last_cnt_f;

  always #5 clk = ~clk;

  pipeline_scoreboard #(.REG_ADDR_W(4), .DEPTH(DEPTH), .FWD_EN(1'b1), .RF_WRITE_THROUGH(1'b1)) dut_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_wb_en(id_wb_en), .id_is_load(id_is_load),
    .id_dest(id_dest), .src1(src1), .src1_used(src1_used), .src2(src2), .two_src(two_src),
    .flush(flush), .stall(stall_f), .fwd_sel1(sel1_f), .fwd_sel2(sel2_f), .busy(busy_f),
    .stall_cycles(cnt_f_o)
  );

  pipeline_scoreboard #(.REG_ADDR_W(4), .DEPTH(DEPTH), .FWD_EN(1'b0), .RF_WRITE_THROUGH(1'b1)) dut_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_wb_en(id_wb_en), .id_is_load(id_is_load),
    .id_dest(id_dest), .src1(src1), .src1_used(src1_used), .src2(src2), .two_src(two_src),
    .flush(flush), .stall(stall_n), .fwd_sel1(sel1_n), .fwd_sel2(sel2_n), .busy(busy_n),
    .stall_cycles(cnt_n_o)
  );

  // Find the youngest in-flight writer of s (WB slot ignored) and derive hazard / forward select.
  function automatic void predict(input ent_t [DEPTH-1:0] m, input bit fwd, input logic [3:0] s,
                                  input logic used, output logic hz, output logic [1:0] sel);
    int youngest;
    youngest = -1;
    hz  = 1'b0;
    sel = 2'd0;
    for (int k = 0; k < DEPTH - 1; k++)
      if (youngest < 0 && m[k].v && m[k].wb && m[k].d == s) youngest = k;
    if (used && youngest >= 0) begin
      if (!fwd) hz = 1'b1;
      else if (youngest == 0 && m[0].ld) hz = 1'b1;
      else sel = 2'(youngest + 1);
    end
  endfunction

  function automatic logic any_valid(input ent_t [DEPTH-1:0] m);
    logic r;
    r = 1'b0;
    for (int k = 0; k < DEPTH; k++) r = r | m[k].v;
    return r;
  endfunction

  task automatic clear_models();
    mf = '0;
    mn = '0;
    mcnt_f = 0;
    mcnt_n = 0;
  endtask

  task automatic step(input logic v, input logic wb, input logic ld, input logic [3:0] d,
                      input logic [3:0] s1, input logic u1, input logic [3:0] s2,
                      input logic two, input logic fl);
    logic h1, h2, est_f, est_n;
    logic [1:0] e1, e2, x1, x2;
    ent_t nf, nn;
    id_valid = v; id_wb_en = wb; id_is_load = ld; id_dest = d;
    src1 = s1; src1_used = u1; src2 = s2; two_src = two; flush = fl;
    #4;
    predict(mf, 1'b1, s1, u1, h1, e1);
    predict(mf, 1'b1, s2, two, h2, e2);
    est_f = v & ~fl & (h1 | h2);
    checks++; if (stall_f !== est_f) begin errors++; $display("FAIL stall_fwd: got %b want %b", stall_f, est_f); end
    checks++; if (busy_f !== any_valid(mf)) begin errors++; $display("FAIL busy_fwd: got %b want %b", busy_f, any_valid(mf)); end
    checks++; if (cnt_f_o !== mcnt_f) begin errors++; $display("FAIL cnt_fwd: got %0d want %0d", cnt_f_o, mcnt_f); end
    if (!est_f && u1) begin
      checks++; if (sel1_f !== e1) begin errors++; $display("FAIL sel1_fwd: got %0d want %0d", sel1_f, e1); end
    end
    if (!est_f && two) begin
      checks++; if (sel2_f !== e2) begin errors++; $display("FAIL sel2_fwd: got %0d want %0d", sel2_f, e2); end
    end
    predict(mn, 1'b0, s1, u1, h1, x1);
    predict(mn, 1'b0, s2, two, h2, x2);
    est_n = v & ~fl & (h1 | h2);
    checks++; if (stall_n !== est_n) begin errors++; $display("FAIL stall_nofwd: got %b want %b", stall_n, est_n); end
    checks++; if (busy_n !== any_valid(mn)) begin errors++; $display("FAIL busy_nofwd: got %b want %b", busy_n, any_valid(mn)); end
    checks++; if (cnt_n_o !== mcnt_n) begin errors++; $display("FAIL cnt_nofwd: got %0d want %0d", cnt_n_o, mcnt_n); end
    checks++; if ({sel1_n, sel2_n} !== 4'd0) begin errors++; $display("FAIL sel_nofwd: got %0d/%0d want 0/0", sel1_n, sel2_n); end
    last_stall_f = stall_f; last_stall_n = stall_n;
    last_sel1_f = sel1_f; last_sel2_f = sel2_f; last_cnt_f = cnt_f_o;
    nf = '{v: v & ~est_f & ~fl, wb: wb, ld: ld, d: d};
    nn = '{v: v & ~est_n & ~fl, wb: wb, ld: ld, d: d};
    if (!nf.v) nf = '0;
    if (!nn.v) nn = '0;
    @(posedge clk);
    mf = {mf[DEPTH-2:0], nf};
    mn = {mn[DEPTH-2:0], nn};
    if (est_f) mcnt_f++;
    if (est_n) mcnt_n++;
    #1;
  endtask

  task automatic bubble();
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (DEPTH) bubble();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    id_valid = 1'b1; id_wb_en = 1'b1; id_is_load = 1'b1; id_dest = 4'd1;
    src1 = 4'd1; src1_used = 1'b1; src2 = 4'd1; two_src = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    checks++; if ({stall_f, stall_n} !== 2'b00) begin errors++; $display("FAIL reset_stall: got %b want 00", {stall_f, stall_n}); end
    checks++; if ({busy_f, busy_n} !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", {busy_f, busy_n}); end
    checks++; if ({sel1_f, sel2_f} !== 4'd0) begin errors++; $display("FAIL reset_sel: got %0d/%0d want 0/0", sel1_f, sel2_f); end
    checks++; if ((cnt_f_o | cnt_n_o) !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0", cnt_f_o, cnt_n_o); end
    id_valid = 1'b0; id_wb_en = 1'b0; id_is_load = 1'b0; src1_used = 1'b0; two_src = 1'b0;
    clear_models();
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    step(1'b1, 1'b1, 1'b1, 4'd4, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'd5, 4'd4, 1'b1, 4'd4, 1'b1, 1'b0);
    checks++; if (last_stall_f !== 1'b1) begin errors++; $display("FAIL loaduse_stall: got %b want 1", last_stall_f); end
    step(1'b1, 1'b1, 1'b0, 4'd5, 4'd4, 1'b1, 4'd4, 1'b1, 1'b0);
    checks++; if (last_stall_f !== 1'b0) begin errors++; $display("FAIL loaduse_release: got %b want 0", last_stall_f); end
    checks++; if ({last_sel1_f, last_sel2_f} !== {2'd2, 2'd2}) begin errors++; $display("FAIL loaduse_sel: got %0d/%0d want 2/2", last_sel1_f, last_sel2_f); end
    checks++; if (last_cnt_f !== 32'd1) begin errors++; $display("FAIL loaduse_cnt: got %0d want 1", last_cnt_f); end
  endtask

  task automatic test_alu_back_to_back();
    drain();
    step(1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'd2, 4'd1, 1'b1, 4'd3, 1'b1, 1'b0);
    checks++; if ({last_stall_f, last_sel1_f} !== {1'b0, 2'd1}) begin errors++; $display("FAIL alu_b2b: got stall %b sel %0d want 0/1", last_stall_f, last_sel1_f); end
    drain();
    step(1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    bubble();
    step(1'b1, 1'b1, 1'b0, 4'd2, 4'd1, 1'b1, 4'd3, 1'b1, 1'b0);
    checks++; if ({last_stall_f, last_sel1_f} !== {1'b0, 2'd2}) begin errors++; $display("FAIL alu_gap: got stall %b sel %0d want 0/2", last_stall_f, last_sel1_f); end
  endtask

  task automatic test_youngest_wins();
    logic [2:0] seen;
    drain();
    step(1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'd2, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0);
    checks++; if (last_sel1_f !== 2'd1) begin errors++; $display("FAIL youngest_sel: got %0d want 1", last_sel1_f); end
    drain();
    step(1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'd2, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0);
      seen[i] = last_stall_n;
    end
    checks++; if (seen !== 3'b011) begin errors++; $display("FAIL nofwd_stall_seq: got %b want 011", seen); end
  endtask

  task automatic test_flush();
    drain();
    step(1'b1, 1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'd7, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1);
    checks++; if (last_stall_f !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", last_stall_f); end
    step(1'b1, 1'b1, 1'b0, 4'd8, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0);
    checks++; if ({last_stall_f, last_sel1_f} !== 3'b000) begin errors++; $display("FAIL flush_r7: got stall %b sel %0d want 0/0", last_stall_f, last_sel1_f); end
  endtask

  task automatic test_async_reset();
    drain();
    step(1'b1, 1'b1, 1'b1, 4'd4, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    id_valid = 1'b1; id_wb_en = 1'b1; id_is_load = 1'b0; id_dest = 4'd5;
    src1 = 4'd4; src1_used = 1'b1; src2 = 4'd0; two_src = 1'b0; flush = 1'b0;
    #3;
    checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL arst_pre_stall: got %b want 1", stall_f); end
    rst = 1'b0;
    #1;
    checks++; if ({stall_f, stall_n} !== 2'b00) begin errors++; $display("FAIL arst_stall: got %b want 00", {stall_f, stall_n}); end
    checks++; if ({busy_f, busy_n} !== 2'b00) begin errors++; $display("FAIL arst_busy: got %b want 00", {busy_f, busy_n}); end
    checks++; if ((cnt_f_o | cnt_n_o) !== 32'd0) begin errors++; $display("FAIL arst_cnt: got %0d/%0d want 0", cnt_f_o, cnt_n_o); end
    id_valid = 1'b0; src1_used = 1'b0;
    clear_models();
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    clear_models();
    test_reset();
    test_load_use();
    test_alu_back_to_back();
    test_youngest_wins();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
